stark_fpu_wb_queue: RTL and testbench

- Sits directly downstream of the FPU reservation station and FPU datapath.
- Captures completed FPU results (one or two targets per op when qfext is set) into a small FIFO.
- Drains the FIFO onto one register-file write port with a valid/ack handshake, then pulses a per-op done to the ROB.
- Its ready output becomes the station's available input, back-pressuring FPU issue.

---
 rtl/stark_fpu_wb_queue_pkg.sv | 36 +++
 rtl/stark_fpu_wb_queue_if.sv | 24 ++
 rtl/stark_fpu_wbq_ram.sv | 47 ++++
 rtl/stark_fpu_wb_queue.sv | 166 ++++++++++++++++
 tb/tb_stark_fpu_wb_queue.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stark_fpu_wb_queue_pkg.sv
// Shared types for the FPU write-back queue: register/ROB index widths, queue entry and drain states.
package stark_fpu_wb_queue_pkg;

  typedef logic [5:0]  rob_ndx_t;
  typedef logic [2:0]  checkpt_ndx_t;
  typedef logic [8:0]  pregno_t;
  typedef logic [5:0]  aregno_t;
  typedef logic [63:0] value_t;
  typedef logic [7:0]  cause_code_t;

  localparam cause_code_t FLT_NONE = 8'h00;

  typedef enum logic [1:0] {WB_IDLE, WB_T0, WB_T1} fpu_wb_state_t;

  typedef struct packed {
    rob_ndx_t     id;
    checkpt_ndx_t cp;
    pregno_t      Rt;
    pregno_t      Rt1;
    aregno_t      aRt;
    aregno_t      aRt1;
    logic         aRtz;
    logic         aRtz1;
    logic         qfext;
    value_t       res;
    value_t       res1;
    cause_code_t  exc;
    logic         v;
  } fpu_wbq_entry_t;

  // An entry whose targets are all r0 completes without touching the register file.
  function automatic logic needs_write(input fpu_wbq_entry_t e);
    return !e.aRtz || (e.qfext && !e.aRtz1);
  endfunction

endpackage

// File: rtl/stark_fpu_wb_queue_if.sv
// Register-file write port and ROB completion bus driven by the FPU write-back queue.
interface stark_fpu_wb_queue_if;
  import stark_fpu_wb_queue_pkg::*;

  logic        wr_v;
  logic        wr_ack;
  pregno_t     wr_preg;
  aregno_t     wr_areg;
  value_t      wr_val;
  logic        done_v;
  rob_ndx_t    done_id;
  cause_code_t done_exc;

  modport master (
    output wr_v, wr_preg, wr_areg, wr_val, done_v, done_id, done_exc,
    input  wr_ack
  );

  modport slave (
    input  wr_v, wr_preg, wr_areg, wr_val, done_v, done_id, done_exc,
    output wr_ack
  );

endinterface

// File: rtl/stark_fpu_wbq_ram.sv
// Queue storage: one write port, two async read ports, per-entry valid bits cleared by checkpoint flush.
module stark_fpu_wbq_ram
  import stark_fpu_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTRW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [PTRW-1:0] waddr,
  input  fpu_wbq_entry_t  wdata,
  input  logic            flush,
  input  checkpt_ndx_t    flush_cp,
  input  logic [PTRW-1:0] raddr0,
  output fpu_wbq_entry_t  rdata0,
  input  logic [PTRW-1:0] raddr1,
  output fpu_wbq_entry_t  rdata1
);

  fpu_wbq_entry_t   mem_q [DEPTH];
  logic [DEPTH-1:0] v_q, clr, set;

  for (genvar g = 0; g < DEPTH; g++) begin : g_clr
    assign clr[g] = flush && (mem_q[g].cp == flush_cp);
  end

  assign set = we ? (DEPTH'(1) << waddr) : '0;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // The top never writes an entry whose checkpoint is being flushed, so set and clr are disjoint.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) v_q <= '0;
    else     v_q <= (v_q & ~clr) | set;
  end

  always_comb begin
    rdata0   = mem_q[raddr0];
    rdata0.v = v_q[raddr0];
    rdata1   = mem_q[raddr1];
    rdata1.v = v_q[raddr1];
  end

endmodule

// File: rtl/stark_fpu_wb_queue.sv
// FPU write-back queue: buffers completed FPU results and drains them onto one register write port,
// then pulses completion to the ROB.
module stark_fpu_wb_queue
  import stark_fpu_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTRW  = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_v,
  input  rob_ndx_t             i_id,
  input  checkpt_ndx_t         i_cp,
  input  pregno_t              i_Rt,
  input  pregno_t              i_Rt1,
  input  aregno_t              i_aRt,
  input  aregno_t              i_aRt1,
  input  logic                 i_aRtz,
  input  logic                 i_aRtz1,
  input  logic                 i_qfext,
  input  value_t               i_res,
  input  value_t               i_res1,
  input  cause_code_t          i_exc,
  output logic                 ready,
  stark_fpu_wb_queue_if.master wb,
  input  logic                 flush,
  input  checkpt_ndx_t         flush_cp,
  output logic [PTRW:0]        count
);

  localparam logic [PTRW:0] FULL = (PTRW + 1)'(DEPTH);
  localparam logic [PTRW:0] ONE  = (PTRW + 1)'(1);

  logic [PTRW-1:0] head_q, tail_q, head_nxt;
  logic [PTRW:0]   cnt_q, cnt_d;
  fpu_wb_state_t   state_q;
  logic            ready_q, wr_v_q, done_v_q;
  pregno_t         wr_preg_q;
  aregno_t         wr_areg_q;
  value_t          wr_val_q;
  rob_ndx_t        done_id_q;
  cause_code_t     done_exc_q;

  fpu_wbq_entry_t  enq_entry, h, n, ld_e;
  logic            enq, pop, h_live, n_live, ld_go;

  assign head_nxt = head_q + PTRW'(1);

  always_comb begin
    enq_entry = '{id: i_id, cp: i_cp, Rt: i_Rt, Rt1: i_Rt1, aRt: i_aRt, aRt1: i_aRt1,
                  aRtz: i_aRtz, aRtz1: i_aRtz1, qfext: i_qfext, res: i_res, res1: i_res1,
                  exc: i_exc, v: 1'b1};
  end

  stark_fpu_wbq_ram #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (enq),
    .waddr    (tail_q),
    .wdata    (enq_entry),
    .flush    (flush),
    .flush_cp (flush_cp),
    .raddr0   (head_q),
    .rdata0   (h),
    .raddr1   (head_nxt),
    .rdata1   (n)
  );

  always_comb begin
    enq    = i_v && ready_q && !(flush && i_cp == flush_cp);
    h_live = h.v && !(flush && h.cp == flush_cp);
    n_live = n.v && !(flush && n.cp == flush_cp);

    // pop retires the head: r0-only or flushed entries in idle, or the final ack of a write.
    pop = 1'b0;
    unique case (state_q)
      WB_IDLE: pop = (cnt_q != '0) && (!h_live || !needs_write(h));
      WB_T0:   pop = !h_live || (wb.wr_ack && !(h.qfext && !h.aRtz1));
      WB_T1:   pop = !h_live || wb.wr_ack;
      default: pop = 1'b0;
    endcase

    // On a final ack the following entry is loaded at once to sustain one write per cycle.
    ld_go = 1'b0;
    ld_e  = h;
    if (state_q == WB_IDLE) begin
      ld_go = (cnt_q != '0) && h_live && needs_write(h);
    end else if (pop && h_live) begin
      ld_go = (cnt_q > ONE) && n_live && needs_write(n);
      ld_e  = n;
    end

    cnt_d = cnt_q;
    if (enq && !pop)      cnt_d = cnt_q + ONE;
    else if (!enq && pop) cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      state_q    <= WB_IDLE;
      ready_q    <= 1'b1;
      wr_v_q     <= 1'b0;
      wr_preg_q  <= '0;
      wr_areg_q  <= '0;
      wr_val_q   <= '0;
      done_v_q   <= 1'b0;
      done_id_q  <= '0;
      done_exc_q <= FLT_NONE;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= cnt_d < FULL;
      if (enq) tail_q <= tail_q + PTRW'(1);
      if (pop) head_q <= head_nxt;

      done_v_q <= pop && h_live;
      if (pop && h_live) begin
        done_id_q  <= h.id;
        done_exc_q <= h.exc;
      end

      if (state_q != WB_IDLE && pop) begin
        wr_v_q  <= 1'b0;
        state_q <= WB_IDLE;
      end else if (state_q == WB_T0 && wb.wr_ack) begin
        state_q   <= WB_T1;
        wr_preg_q <= h.Rt1;
        wr_areg_q <= h.aRt1;
        wr_val_q  <= h.res1;
      end

      if (ld_go) begin
        wr_v_q <= 1'b1;
        if (!ld_e.aRtz) begin
          state_q   <= WB_T0;
          wr_preg_q <= ld_e.Rt;
          wr_areg_q <= ld_e.aRt;
          wr_val_q  <= ld_e.res;
        end else begin
          state_q   <= WB_T1;
          wr_preg_q <= ld_e.Rt1;
          wr_areg_q <= ld_e.aRt1;
          wr_val_q  <= ld_e.res1;
        end
      end
    end
  end

  assign ready       = ready_q;
  assign count       = cnt_q;
  assign wb.wr_v     = wr_v_q;
  assign wb.wr_preg  = wr_preg_q;
  assign wb.wr_areg  = wr_areg_q;
  assign wb.wr_val   = wr_val_q;
  assign wb.done_v   = done_v_q;
  assign wb.done_id  = done_id_q;
  assign wb.done_exc = done_exc_q;

  count_bound_a: assert property (@(posedge clk) disable iff (rst) cnt_q <= FULL);

endmodule

// File: tb/tb_stark_fpu_wb_queue.sv
// Bench for stark_fpu_wb_queue: directed scenarios plus a randomized run against an ordered
// write/done reference model.
module tb_stark_fpu_wb_queue;
  import stark_fpu_wb_queue_pkg::*;

  typedef struct packed {
    pregno_t preg;
    aregno_t areg;
    value_t  val;
  } wr_t;

  typedef struct packed {
    rob_ndx_t    id;
    cause_code_t exc;
  } done_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_v;
  rob_ndx_t     i_id;
  checkpt_ndx_t i_cp;
  pregno_t      i_Rt, i_Rt1;
  aregno_t      i_aRt, i_aRt1;
  logic         i_aRtz, i_aRtz1, i_qfext;
  value_t       i_res, i_res1;
  cause_code_t  i_exc;
  logic         ready;
  logic         flush;
  checkpt_ndx_t flush_cp;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  wr_t   obs_wr[$];
  done_t obs_done[$];

  stark_fpu_wb_queue_if wb ();

  stark_fpu_wb_queue #(
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_v      (i_v),
    .i_id     (i_id),
    .i_cp     (i_cp),
    .i_Rt     (i_Rt),
    .i_Rt1    (i_Rt1),
    .i_aRt    (i_aRt),
    .i_aRt1   (i_aRt1),
    .i_aRtz   (i_aRtz),
    .i_aRtz1  (i_aRtz1),
    .i_qfext  (i_qfext),
    .i_res    (i_res),
    .i_res1   (i_res1),
    .i_exc    (i_exc),
    .ready    (ready),
    .wb       (wb),
    .flush    (flush),
    .flush_cp (flush_cp),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Record every accepted write and every done pulse, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb.wr_v && wb.wr_ack) obs_wr.push_back('{preg: wb.wr_preg, areg: wb.wr_areg, val: wb.wr_val});
      if (wb.done_v) obs_done.push_back('{id: wb.done_id, exc: wb.done_exc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input fpu_wbq_entry_t e);
    i_v = 1'b1;  i_id = e.id;   i_cp = e.cp;   i_Rt = e.Rt;       i_Rt1 = e.Rt1;
    i_aRt = e.aRt; i_aRt1 = e.aRt1; i_aRtz = e.aRtz; i_aRtz1 = e.aRtz1; i_qfext = e.qfext;
    i_res = e.res; i_res1 = e.res1; i_exc = e.exc;
  endtask

  task automatic send(input fpu_wbq_entry_t e);
    present(e);
    step();
    i_v = 1'b0;
  endtask

  function automatic fpu_wbq_entry_t rnd_op(input rob_ndx_t id);
    fpu_wbq_entry_t e;
    e.id    = id;
    e.cp    = checkpt_ndx_t'($urandom);
    e.Rt    = pregno_t'($urandom);
    e.Rt1   = pregno_t'($urandom);
    e.aRt   = aregno_t'($urandom);
    e.aRt1  = aregno_t'($urandom);
    e.aRtz  = ($urandom_range(0, 3) == 0);
    e.aRtz1 = ($urandom_range(0, 3) == 0);
    e.qfext = 1'($urandom);
    e.res   = {$urandom, $urandom};
    e.res1  = {$urandom, $urandom};
    e.exc   = ($urandom_range(0, 3) == 0) ? cause_code_t'($urandom_range(1, 255)) : FLT_NONE;
    e.v     = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ready); end
    checks++; if (wb.wr_v !== 1'b0) begin errors++; $display("FAIL reset_wr_v got %0b want 0", wb.wr_v); end
    checks++; if (wb.done_v !== 1'b0) begin errors++; $display("FAIL reset_done_v got %0b want 0", wb.done_v); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if (wb.wr_preg !== '0 || wb.wr_areg !== '0 || wb.wr_val !== '0) begin
      errors++; $display("FAIL reset_wr_bus got %0d/%0d/%0h want 0", wb.wr_preg, wb.wr_areg, wb.wr_val);
    end
    checks++;
    if (wb.done_id !== '0 || wb.done_exc !== FLT_NONE) begin
      errors++; $display("FAIL reset_done_bus got %0d/%0h want 0/%0h", wb.done_id, wb.done_exc, FLT_NONE);
    end
  endtask

  task automatic test_single();
    fpu_wbq_entry_t e = rnd_op(6'd5);
    e.Rt = 9'd37; e.aRt = 6'd3; e.aRtz = 1'b0; e.qfext = 1'b0;
    e.res = 64'h3FF0_0000_0000_0000; e.exc = FLT_NONE;
    wb.wr_ack = 1'b1;
    send(e);
    checks++; if (count !== 3'd1 || wb.wr_v !== 1'b0) begin
      errors++; $display("FAIL single_enq count %0d wr_v %0b want 1/0", count, wb.wr_v); end
    step();
    checks++; if (wb.wr_v !== 1'b1 || wb.wr_preg !== 9'd37 || wb.wr_areg !== 6'd3) begin
      errors++; $display("FAIL single_wr wr_v %0b preg %0d areg %0d want 1/37/3", wb.wr_v, wb.wr_preg, wb.wr_areg); end
    checks++; if (wb.wr_val !== 64'h3FF0_0000_0000_0000) begin
      errors++; $display("FAIL single_val got %0h want 3ff0000000000000", wb.wr_val); end
    step();
    checks++; if (wb.done_v !== 1'b1 || wb.done_id !== 6'd5 || wb.wr_v !== 1'b0) begin
      errors++; $display("FAIL single_done done_v %0b id %0d wr_v %0b want 1/5/0", wb.done_v, wb.done_id, wb.wr_v); end
    step();
    checks++; if (wb.done_v !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL single_after done_v %0b count %0d want 0/0", wb.done_v, count); end
  endtask

  task automatic test_qfext();
    fpu_wbq_entry_t e = rnd_op(6'd7);
    e.Rt = 9'd10; e.Rt1 = 9'd11; e.aRtz = 1'b0; e.aRtz1 = 1'b0; e.qfext = 1'b1;
    e.res = 64'd1; e.res1 = 64'd2;
    wb.wr_ack = 1'b1;
    send(e);
    step();
    checks++; if (wb.wr_v !== 1'b1 || wb.wr_preg !== 9'd10 || wb.wr_val !== 64'd1) begin
      errors++; $display("FAIL qfext_t0 wr_v %0b preg %0d val %0h want 1/10/1", wb.wr_v, wb.wr_preg, wb.wr_val); end
    step();
    checks++; if (wb.wr_v !== 1'b1 || wb.wr_preg !== 9'd11 || wb.wr_val !== 64'd2 || wb.done_v !== 1'b0) begin
      errors++; $display("FAIL qfext_t1 wr_v %0b preg %0d val %0h done %0b want 1/11/2/0",
                         wb.wr_v, wb.wr_preg, wb.wr_val, wb.done_v); end
    step();
    checks++; if (wb.done_v !== 1'b1 || wb.done_id !== 6'd7 || wb.wr_v !== 1'b0) begin
      errors++; $display("FAIL qfext_done done_v %0b id %0d wr_v %0b want 1/7/0", wb.done_v, wb.done_id, wb.wr_v); end
    step();
    checks++; if (wb.done_v !== 1'b0) begin errors++; $display("FAIL qfext_single_done got %0b want 0", wb.done_v); end
  endtask

  task automatic test_rtz();
    fpu_wbq_entry_t e = rnd_op(6'd9);
    e.aRtz = 1'b1; e.qfext = 1'b0;
    wb.wr_ack = 1'b1;
    obs_wr.delete();
    obs_done.delete();
    send(e);
    step();
    checks++; if (wb.done_v !== 1'b1 || wb.done_id !== 6'd9) begin
      errors++; $display("FAIL rtz_done done_v %0b id %0d want 1/9", wb.done_v, wb.done_id); end
    step();
    step();
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL rtz_no_write got %0d writes want 0", obs_wr.size()); end
    checks++; if (obs_done.size() != 1) begin errors++; $display("FAIL rtz_done_cnt got %0d want 1", obs_done.size()); end
  endtask

  task automatic test_backpressure();
    fpu_wbq_entry_t ops[4];
    wb.wr_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ops[k] = rnd_op(rob_ndx_t'(10 + k));
      ops[k].aRtz = 1'b0; ops[k].qfext = 1'b0;
    end
    for (int k = 0; k < 4; k++) send(ops[k]);
    checks++; if (ready !== 1'b0 || count !== 3'd4) begin
      errors++; $display("FAIL bp_full ready %0b count %0d want 0/4", ready, count); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (wb.wr_v !== 1'b1 || wb.wr_preg !== ops[0].Rt || wb.wr_areg !== ops[0].aRt ||
          wb.wr_val !== ops[0].res) begin
        errors++; $display("FAIL bp_hold cycle %0d wr_v %0b preg %0d want 1/%0d", k, wb.wr_v, wb.wr_preg, ops[0].Rt);
      end
      step();
    end
    obs_wr.delete();
    obs_done.delete();
    wb.wr_ack = 1'b1;
    repeat (8) step();
    checks++; if (obs_wr.size() != 4 || obs_done.size() != 4) begin
      errors++; $display("FAIL bp_drain writes %0d dones %0d want 4/4", obs_wr.size(), obs_done.size()); end
    for (int k = 0; k < 4 && k < obs_wr.size() && k < obs_done.size(); k++) begin
      checks++;
      if (obs_wr[k].preg !== ops[k].Rt || obs_wr[k].val !== ops[k].res || obs_done[k].id !== ops[k].id) begin
        errors++; $display("FAIL bp_order %0d preg %0d id %0d want %0d/%0d",
                           k, obs_wr[k].preg, obs_done[k].id, ops[k].Rt, ops[k].id);
      end
    end
    checks++; if (count !== 3'd0 || ready !== 1'b1) begin
      errors++; $display("FAIL bp_empty count %0d ready %0b want 0/1", count, ready); end
  endtask

  task automatic test_flush();
    fpu_wbq_entry_t ops[4];
    fpu_wbq_entry_t e;
    checkpt_ndx_t   cps[4] = '{3'd1, 3'd2, 3'd2, 3'd3};
    wb.wr_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ops[k] = rnd_op(rob_ndx_t'(20 + k));
      ops[k].cp = cps[k]; ops[k].aRtz = 1'b0; ops[k].qfext = 1'b0;
    end
    for (int k = 0; k < 4; k++) send(ops[k]);
    obs_wr.delete();
    obs_done.delete();
    flush = 1'b1; flush_cp = 3'd2;
    step();
    flush = 1'b0;
    wb.wr_ack = 1'b1;
    repeat (10) step();
    checks++; if (obs_wr.size() != 2 || obs_done.size() != 2) begin
      errors++; $display("FAIL flush_cnt writes %0d dones %0d want 2/2", obs_wr.size(), obs_done.size()); end
    else begin
      checks++; if (obs_wr[0].preg !== ops[0].Rt || obs_wr[1].preg !== ops[3].Rt) begin
        errors++; $display("FAIL flush_wr pregs %0d,%0d want %0d,%0d", obs_wr[0].preg, obs_wr[1].preg, ops[0].Rt, ops[3].Rt); end
      checks++; if (obs_done[0].id !== 6'd20 || obs_done[1].id !== 6'd23) begin
        errors++; $display("FAIL flush_done ids %0d,%0d want 20,23", obs_done[0].id, obs_done[1].id); end
    end
    // Flush of the head while its write is stalled.
    wb.wr_ack = 1'b0;
    e = rnd_op(6'd24);
    e.cp = 3'd2; e.aRtz = 1'b0;
    obs_done.delete();
    send(e);
    step();
    checks++; if (wb.wr_v !== 1'b1) begin errors++; $display("FAIL flush_mid_pre wr_v %0b want 1", wb.wr_v); end
    flush = 1'b1; flush_cp = 3'd2;
    step();
    flush = 1'b0;
    checks++; if (wb.wr_v !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL flush_mid wr_v %0b count %0d want 0/0", wb.wr_v, count); end
    // Enqueue in the same cycle as a flush of its own checkpoint.
    obs_wr.delete();
    e = rnd_op(6'd25);
    e.cp = 3'd2; e.aRtz = 1'b0;
    present(e);
    flush = 1'b1; flush_cp = 3'd2;
    step();
    i_v = 1'b0; flush = 1'b0;
    wb.wr_ack = 1'b1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_enq_drop count %0d want 0", count); end
    repeat (3) step();
    checks++; if (obs_wr.size() != 0 || obs_done.size() != 0) begin
      errors++; $display("FAIL flush_quiet writes %0d dones %0d want 0/0", obs_wr.size(), obs_done.size()); end
  endtask

  task automatic test_random();
    wr_t   exp_wr[$];
    done_t exp_done[$];
    fpu_wbq_entry_t e;
    int sent = 0;
    int cyc  = 0;
    obs_wr.delete();
    obs_done.delete();
    while (sent < 60 && cyc < 3000) begin
      wb.wr_ack = ($urandom_range(0, 9) < 7);
      if (ready && $urandom_range(0, 3) != 0) begin
        e = rnd_op(rob_ndx_t'(sent));
        present(e);
        if (!e.aRtz) exp_wr.push_back('{preg: e.Rt, areg: e.aRt, val: e.res});
        if (e.qfext && !e.aRtz1) exp_wr.push_back('{preg: e.Rt1, areg: e.aRt1, val: e.res1});
        exp_done.push_back('{id: e.id, exc: e.exc});
        sent++;
      end else begin
        i_v = 1'b0;
      end
      step();
      cyc++;
    end
    i_v = 1'b0;
    wb.wr_ack = 1'b1;
    cyc = 0;
    while ((count != 3'd0 || wb.wr_v) && cyc < 300) begin
      step();
      cyc++;
    end
    checks++; if (cyc >= 300) begin errors++; $display("FAIL rand_drain_timeout count %0d wr_v %0b", count, wb.wr_v); end
    repeat (2) step();
    checks++; if (obs_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL rand_wr_cnt got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    checks++; if (obs_done.size() != exp_done.size()) begin
      errors++; $display("FAIL rand_done_cnt got %0d want %0d", obs_done.size(), exp_done.size()); end
    for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++) begin
      checks++; if (obs_wr[k] !== exp_wr[k]) begin
        errors++; $display("FAIL rand_wr %0d got %0d/%0d/%0h want %0d/%0d/%0h", k, obs_wr[k].preg, obs_wr[k].areg,
                           obs_wr[k].val, exp_wr[k].preg, exp_wr[k].areg, exp_wr[k].val); end
    end
    for (int k = 0; k < exp_done.size() && k < obs_done.size(); k++) begin
      checks++; if (obs_done[k] !== exp_done[k]) begin
        errors++; $display("FAIL rand_done %0d got %0d/%0h want %0d/%0h", k, obs_done[k].id, obs_done[k].exc,
                           exp_done[k].id, exp_done[k].exc); end
    end
  endtask

  task automatic test_reset_mid_t1();
    fpu_wbq_entry_t e = rnd_op(6'd30);
    e.Rt = 9'd40; e.Rt1 = 9'd41; e.aRtz = 1'b0; e.aRtz1 = 1'b0; e.qfext = 1'b1;
    wb.wr_ack = 1'b1;
    send(e);
    step();
    step();
    wb.wr_ack = 1'b0;
    checks++; if (wb.wr_v !== 1'b1 || wb.wr_preg !== 9'd41) begin
      errors++; $display("FAIL rst_t1_pre wr_v %0b preg %0d want 1/41", wb.wr_v, wb.wr_preg); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wb.wr_v !== 1'b0 || wb.done_v !== 1'b0 || count !== 3'd0 || ready !== 1'b1) begin
      errors++; $display("FAIL rst_async wr_v %0b done_v %0b count %0d ready %0b want 0/0/0/1",
                         wb.wr_v, wb.done_v, count, ready); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (wb.wr_v !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL rst_after wr_v %0b count %0d want 0/0", wb.wr_v, count); end
  endtask

  initial begin
    rst = 1'b1; i_v = 1'b0; i_id = '0; i_cp = '0; i_Rt = '0; i_Rt1 = '0; i_aRt = '0; i_aRt1 = '0;
    i_aRtz = 1'b0; i_aRtz1 = 1'b0; i_qfext = 1'b0; i_res = '0; i_res1 = '0; i_exc = FLT_NONE;
    flush = 1'b0; flush_cp = '0; wb.wr_ack = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    test_single();
    test_qfext();
    test_rtz();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid_t1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
